// File: rtl/pmem_burst_responder_if.sv
// pmem_* bus between the core's cacheline adaptor and a line responder.
// master = initiator side, slave = memory side.
interface pmem_burst_responder_if;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_addr;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        pmem_err;

  modport master (
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_resp, pmem_rdata, pmem_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_resp, pmem_rdata, pmem_err
  );
endinterface

// File: rtl/pmem_burst_responder.sv
// Fixed-latency, four-beat 64-bit line responder for the pmem_* port.
// Line-organised RAM; contents survive reset.
module pmem_burst_responder #(
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 10
) (
  input logic                    clk,
  input logic                    rst,
  pmem_burst_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_e;

  localparam int          NWORDS   = 4 << LINE_IDX_W;
  localparam logic [7:0]  LAT_INIT = 8'(LATENCY - 1);

  logic [63:0] mem_q [NWORDS];

  state_e                  state_q, state_d;
  logic [7:0]              lat_q, lat_d;
  logic [1:0]              beat_q, beat_d;
  logic [LINE_IDX_W-1:0]   line_q, line_d;
  logic                    wr_q, wr_d;
  logic                    resp_q, resp_d;
  logic [63:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic unused_addr;
  assign unused_addr = ^{bus.pmem_addr[31:5+LINE_IDX_W],
                         bus.pmem_addr[4:0]};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    line_d  = line_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.pmem_read ^ bus.pmem_write) begin
          line_d  = bus.pmem_addr[5 +: LINE_IDX_W];
          wr_d    = bus.pmem_write;
          lat_d   = LAT_INIT;
          beat_d  = 2'd0;
          state_d = WAIT;
        end else if (bus.pmem_read && bus.pmem_write) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (lat_q == 8'd0) begin
          beat_d  = 2'd0;
          state_d = BURST;
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      BURST: begin
        if (beat_q == 2'd3) begin
          beat_d  = 2'd0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so decode them from next-state values.
    resp_d  = (state_d == BURST);
    rdata_d = (resp_d && !wr_d) ? mem_q[{line_d, beat_d}] : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= 8'd0;
      beat_q  <= 2'd0;
      line_q  <= '0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A reset edge aborts the burst before the beat under way is committed.
  always_ff @(posedge clk) begin
    if (!rst && state_q == BURST && wr_q)
      mem_q[{line_q, beat_q}] <= bus.pmem_wdata;
  end

  assign bus.pmem_resp  = resp_q;
  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_err   = err_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// Directed bench for pmem_burst_responder (LATENCY=10, 256 lines).
// Inputs driven on negedge, outputs sampled on negedge.
module tb_pmem_burst_responder;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pmem_burst_responder_if bus ();

  pmem_burst_responder #(
    .LINE_IDX_W (8),
    .LATENCY    (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One burst from an idle responder; checks every cycle E1..E15.
  task automatic burst(input string tag, input bit wr,
                       input logic [31:0] a,
                       input logic [3:0][63:0] d);
    bit on;
    @(negedge clk);
    bus.pmem_read  = !wr;
    bus.pmem_write = wr;
    bus.pmem_addr  = a;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_addr  = 32'hdead_beef;
      end
      on = (k >= 10 && k <= 13);
      chk({tag, "_resp"}, 64'(bus.pmem_resp), 64'(on));
      chk({tag, "_rdata"}, bus.pmem_rdata,
          (on && !wr) ? d[k-10] : 64'd0);
      bus.pmem_wdata = (on && wr) ? d[k-10] : {$urandom, $urandom};
    end
  endtask

  logic [3:0][63:0] l3, l4, nw, mix, al;
  int first;

  initial begin
    l3  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l4  = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
           64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    nw  = {64'hdddd_0000_0000_0004, 64'hcccc_0000_0000_0003,
           64'hbbbb_0000_0000_0002, 64'haaaa_0000_0000_0001};
    mix = {l3[3], l3[2], nw[1], nw[0]};
    al  = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
           64'h0f0f_0f0f_f0f0_f0f0, 64'hcafe_f00d_dead_beef};

    rst            = 1'b1;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_addr  = 32'd0;
    bus.pmem_wdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", 64'(bus.pmem_resp), 64'd0);
    chk("rst_rdata", bus.pmem_rdata, 64'd0);
    chk("rst_err", 64'(bus.pmem_err), 64'd0);
    rst = 1'b0;

    burst("wr_l3", 1'b1, 32'h0000_0060, l3);
    burst("rd_l3", 1'b0, 32'h0000_0060, l3);
    burst("wr_l4", 1'b1, 32'h0000_0080, l4);

    // Back-to-back: read held continuously, address changed mid-burst.
    @(negedge clk);
    bus.pmem_read = 1'b1;
    bus.pmem_addr = 32'h0000_0060;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) bus.pmem_addr = 32'h0000_0080;
      chk("b2b1_resp", 64'(bus.pmem_resp),
          64'(k >= 10 && k <= 13));
      chk("b2b1_rdata", bus.pmem_rdata,
          (k >= 10 && k <= 13) ? l3[k-10] : 64'd0);
    end
    first = 0;
    for (int k = 15; k <= 30 && first == 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.pmem_resp) first = k;
    end
    bus.pmem_read = 1'b0;
    chk("b2b2_not_early", 64'(first >= 25), 64'd1);
    chk("b2b2_no_timeout", 64'(first != 0 && first <= 26), 64'd1);
    chk("b2b2_beat0", bus.pmem_rdata, l4[0]);
    for (int b = 1; b <= 3; b++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b2_resp", 64'(bus.pmem_resp), 64'd1);
      chk("b2b2_rdata", bus.pmem_rdata, l4[b]);
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("b2b2_tail_resp", 64'(bus.pmem_resp), 64'd0);
    end

    // Both requests high: error, no burst.
    @(negedge clk);
    bus.pmem_read  = 1'b1;
    bus.pmem_write = 1'b1;
    bus.pmem_addr  = 32'h0000_0080;
    @(posedge clk);
    @(negedge clk);
    chk("ill_err", 64'(bus.pmem_err), 64'd1);
    chk("ill_resp", 64'(bus.pmem_resp), 64'd0);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      chk("ill_no_resp", 64'(bus.pmem_resp), 64'd0);
    end
    burst("ill_rd_l4", 1'b0, 32'h0000_0080, l4);
    chk("ill_err_sticky", 64'(bus.pmem_err), 64'd1);

    // Reset right after write beat 1 is taken.
    @(negedge clk);
    bus.pmem_write = 1'b1;
    bus.pmem_addr  = 32'h0000_0060;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) bus.pmem_write = 1'b0;
      chk("rmb_resp", 64'(bus.pmem_resp), 64'(k >= 10));
      if (k >= 10) bus.pmem_wdata = nw[k-10];
      if (k == 12) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rmb_resp_drop", 64'(bus.pmem_resp), 64'd0);
    chk("rmb_rdata", bus.pmem_rdata, 64'd0);
    chk("rmb_err_clr", 64'(bus.pmem_err), 64'd0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("rmb_quiet", 64'(bus.pmem_resp), 64'd0);
    end
    burst("rmb_rd", 1'b0, 32'h0000_0060, mix);

    // Offset bits ignored, address wraps at 8 KiB.
    burst("al_wr", 1'b1, 32'h0000_0064, al);
    burst("al_rd", 1'b0, 32'h0000_2060, al);
    burst("al_l4", 1'b0, 32'h0000_209f, l4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
